operand_stage: RTL and testbench

OPERAND_STAGE -- requirements
Module: operand_stage

---
 rtl/operand_stage.sv | 136 +++++++++++++
 tb/tb_operand_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stage.sv
// operand_stage: bypass-resolved operand selection with a 1-cycle registered output slot.
// Optional hazard-stall counter enabled by defining OPERAND_STAGE_STALL_CNT_EN.
module operand_stage #(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2,
  parameter int RADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_pc,
  input  logic [5:0]                 in_op,
  input  logic [5:0]                 in_funct,
  input  logic [15:0]                in_imm,
  input  logic [RADDR_W-1:0]         in_rs_addr,
  input  logic [RADDR_W-1:0]         in_rt_addr,
  input  logic [DATA_W-1:0]          in_rs_data,
  input  logic [DATA_W-1:0]          in_rt_data,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD-1:0]         fwd_pend,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_operand_1,
  output logic [DATA_W-1:0]          out_operand_2,
  output logic [DATA_W-1:0]          out_pc,
  output logic [15:0]                stall_count
);
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_JALR    = 6'h09;
  logic [DATA_W-1:0] rs_val, rt_val, link, op1, op2;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic              rs_pend, rt_pend, use_rs, use_rt, hazard, xfer;
  // Walk oldest to youngest so the lowest-index match wins.
  always_comb begin
    rs_val  = (in_rs_addr == '0) ? '0 : in_rs_data;
    rt_val  = (in_rt_addr == '0) ? '0 : in_rt_data;
    rs_pend = 1'b0;
    rt_pend = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && in_rs_addr != '0 && fwd_addr[i*RADDR_W +: RADDR_W] == in_rs_addr) begin
        rs_val  = fwd_data[i*DATA_W +: DATA_W];
        rs_pend = fwd_pend[i];
      end
      if (fwd_valid[i] && in_rt_addr != '0 && fwd_addr[i*RADDR_W +: RADDR_W] == in_rt_addr) begin
        rt_val  = fwd_data[i*DATA_W +: DATA_W];
        rt_pend = fwd_pend[i];
      end
    end
  end
  always_comb begin
    link   = in_pc + DATA_W'(8);
    use_rs = 1'b0;
    use_rt = 1'b0;
    op1    = '0;
    op2    = '0;
    case (in_op)
      OP_ADDIU, OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW: begin
        use_rs = 1'b1;
        op1    = rs_val;
        op2    = {{(DATA_W-16){in_imm[15]}}, in_imm};
      end
      OP_LUI: begin
        use_rs = 1'b1;
        op1    = rs_val;
        op2    = {in_imm, {(DATA_W-16){1'b0}}};
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        use_rs = 1'b1;
        op1    = rs_val;
        op2    = {{(DATA_W-16){1'b0}}, in_imm};
      end
      OP_SPECIAL: begin
        use_rs = in_funct != FN_JALR;
        use_rt = 1'b1;
        op1    = (in_funct == FN_JALR) ? link : rs_val;
        op2    = rt_val;
      end
      OP_JAL:  op1 = link;
      default: ;
    endcase
  end
  assign hazard   = (use_rs & rs_pend) | (use_rt & rt_pend);
  assign in_ready = rst_n & (!out_valid_q | out_ready) & !hazard & !flush;
  assign xfer     = in_valid & in_ready;
  always_comb begin
    out_valid_d = flush ? 1'b0 : xfer ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    op1_d       = xfer ? op1 : op1_q;
    op2_d       = xfer ? op2 : op2_q;
    pc_d        = xfer ? in_pc : pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      pc_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      pc_q        <= pc_d;
    end
  end
  assign out_valid     = out_valid_q;
  assign out_operand_1 = op1_q;
  assign out_operand_2 = op2_q;
  assign out_pc        = pc_q;
`ifdef OPERAND_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  always_comb
    stall_cnt_d = (in_valid && hazard && !flush && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: scoreboard-driven bench for operand_stage (default parameters).
module tb_operand_stage;
  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
  } exp_t;
`ifdef OPERAND_STAGE_STALL_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd3;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_pc = 0, in_rs_data = 0, in_rt_data = 0;
  logic [5:0]  in_op = 0, in_funct = 0;
  logic [15:0] in_imm = 0;
  logic [4:0]  in_rs_addr = 0, in_rt_addr = 0;
  logic [1:0]  fwd_valid = 0, fwd_pend = 0;
  logic [9:0]  fwd_addr = 0;
  logic [63:0] fwd_data = 0;
  logic        in_ready, out_valid;
  logic [31:0] out_operand_1, out_operand_2, out_pc;
  logic [15:0] stall_count;

  operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_op(in_op), .in_funct(in_funct), .in_imm(in_imm),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .fwd_valid(fwd_valid), .fwd_pend(fwd_pend), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_operand_1(out_operand_1),
    .out_operand_2(out_operand_2), .out_pc(out_pc), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] funct, input logic [15:0] imm,
                       input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd);
    in_valid = 1; in_op = op; in_funct = funct; in_imm = imm; in_pc = pc;
    in_rs_addr = rs; in_rt_addr = rt; in_rs_data = rsd; in_rt_data = rtd;
  endtask

  task automatic test_reset;
    rst_n = 0;
    drive(6'h09, 6'h00, 16'h0001, 32'h50, 5'd1, 5'd0, 32'h5, 32'h0);
    tick;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_checks++; if ({out_operand_1, out_operand_2, out_pc} !== 96'h0) begin n_fail++; $display("FAIL reset outputs: got %h/%h/%h want zeros", out_operand_1, out_operand_2, out_pc); end
    n_checks++; if (stall_count !== 16'h0) begin n_fail++; $display("FAIL reset stall_count: got %h want 0", stall_count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    in_valid = 0;
    rst_n = 1;
    tick;
  endtask

  task automatic test_addiu;
    exp_t e;
    drive(6'h09, 6'h00, 16'hFFFE, 32'h200, 5'd3, 5'd0, 32'h10, 32'h0);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addiu in_ready: got %b want 1", in_ready); end
    sb.push_back({32'h10, 32'hFFFFFFFE, 32'h200});
    tick;
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL addiu out_valid: got %b want 1", out_valid); end
    else begin
      e = sb.pop_front();
      n_checks++; if ({out_operand_1, out_operand_2, out_pc} !== e) begin n_fail++; $display("FAIL addiu result: got %h/%h/%h want %h/%h/%h", out_operand_1, out_operand_2, out_pc, e.op1, e.op2, e.pc); end
    end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addiu drain out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_ops;
    exp_t e;
    logic [5:0]  ops [14] = '{6'h09, 6'h0F, 6'h0D, 6'h0C, 6'h0E, 6'h20, 6'h23, 6'h24, 6'h28, 6'h2B, 6'h00, 6'h00, 6'h03, 6'h04};
    logic [5:0]  fns [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h21, 6'h09, 6'h00, 6'h00};
    logic [31:0] e1 [14]  = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678,
                              32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h00001034, 32'h00001038, 32'h0};
    logic [31:0] e2 [14]  = '{32'hFFFF8001, 32'h80010000, 32'h00008001, 32'h00008001, 32'h00008001, 32'hFFFF8001, 32'hFFFF8001,
                              32'hFFFF8001, 32'hFFFF8001, 32'hFFFF8001, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h0, 32'h0};
    for (int k = 0; k < 14; k++) begin
      drive(ops[k], fns[k], 16'h8001, 32'h1000 + 32'(4 * k), 5'd3, 5'd7, 32'h12345678, 32'h9ABCDEF0);
      sb.push_back({e1[k], e2[k], 32'h1000 + 32'(4 * k)});
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ops[%0d] in_ready: got %b want 1", k, in_ready); end
      tick;
      n_checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL ops[%0d] out_valid: got %b want 1", k, out_valid); end
      else begin
        e = sb.pop_front();
        n_checks++; if ({out_operand_1, out_operand_2, out_pc} !== e) begin n_fail++; $display("FAIL ops[%0d] result: got %h/%h/%h want %h/%h/%h", k, out_operand_1, out_operand_2, out_pc, e.op1, e.op2, e.pc); end
      end
    end
    in_valid = 0;
    tick;
  endtask

  task automatic test_jal_wrap;
    exp_t e;
    drive(6'h03, 6'h00, 16'h1234, 32'hFFFFFFFC, 5'd5, 5'd6, 32'hDEAD, 32'hBEEF);
    sb.push_back({32'h00000004, 32'h0, 32'hFFFFFFFC});
    tick;
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL jal_wrap out_valid: got %b want 1", out_valid); end
    else begin
      e = sb.pop_front();
      n_checks++; if ({out_operand_1, out_operand_2, out_pc} !== e) begin n_fail++; $display("FAIL jal_wrap result: got %h/%h/%h want %h/%h/%h", out_operand_1, out_operand_2, out_pc, e.op1, e.op2, e.pc); end
    end
    tick;
  endtask

  task automatic test_bypass;
    exp_t e;
    logic [1:0]  fv [6] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b11, 2'b11};
    logic [9:0]  fa [6] = '{{5'd4, 5'd4}, {5'd4, 5'd4}, {5'd4, 5'd4}, {5'd4, 5'd4}, {5'd0, 5'd0}, {5'd4, 5'd6}};
    logic [4:0]  ra [6] = '{5'd4, 5'd0, 5'd4, 5'd4, 5'd0, 5'd4};
    logic [4:0]  ta [6] = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd6};
    logic [31:0] rd [6] = '{32'h11, 32'h77, 32'h11, 32'h11, 32'h77, 32'h11};
    logic [31:0] td [6] = '{32'h55, 32'h55, 32'h22, 32'h22, 32'h88, 32'h22};
    logic [31:0] e1 [6] = '{32'hAA, 32'h0, 32'hBB, 32'h11, 32'h0, 32'hBB};
    logic [31:0] e2 [6] = '{32'h0, 32'h0, 32'hBB, 32'h22, 32'h0, 32'hAA};
    fwd_data = {32'hBB, 32'hAA};
    for (int k = 0; k < 6; k++) begin
      fwd_valid = fv[k];
      fwd_addr = fa[k];
      drive(6'h00, 6'h21, 16'h0, 32'h300 + 32'(4 * k), ra[k], ta[k], rd[k], td[k]);
      sb.push_back({e1[k], e2[k], 32'h300 + 32'(4 * k)});
      tick;
      n_checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL bypass[%0d] out_valid: got %b want 1", k, out_valid); end
      else begin
        e = sb.pop_front();
        n_checks++; if ({out_operand_1, out_operand_2, out_pc} !== e) begin n_fail++; $display("FAIL bypass[%0d] result: got %h/%h/%h want %h/%h/%h", k, out_operand_1, out_operand_2, out_pc, e.op1, e.op2, e.pc); end
      end
    end
    in_valid = 0;
    fwd_valid = 0;
    tick;
  endtask

  task automatic test_hazard;
    exp_t e;
    fwd_valid = 2'b01;
    fwd_pend = 2'b01;
    fwd_addr = {5'd0, 5'd5};
    fwd_data = {32'h0, 32'h500};
    drive(6'h23, 6'h00, 16'h0010, 32'h400, 5'd5, 5'd0, 32'h99, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hazard stall[%0d] in_ready: got %b want 0", k, in_ready); end
      tick;
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hazard accepted early: out_valid got %b want 0", out_valid); end
    n_checks++; if (stall_count !== STALL_EXP) begin n_fail++; $display("FAIL hazard stall_count: got %0d want %0d", stall_count, STALL_EXP); end
    fwd_pend = 2'b00;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hazard release in_ready: got %b want 1", in_ready); end
    sb.push_back({32'h500, 32'h10, 32'h400});
    tick;
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL hazard out_valid: got %b want 1", out_valid); end
    else begin
      e = sb.pop_front();
      n_checks++; if ({out_operand_1, out_operand_2, out_pc} !== e) begin n_fail++; $display("FAIL hazard result: got %h/%h/%h want %h/%h/%h", out_operand_1, out_operand_2, out_pc, e.op1, e.op2, e.pc); end
    end
    fwd_pend = 2'b01;
    drive(6'h03, 6'h00, 16'h0, 32'h500, 5'd5, 5'd5, 32'h0, 32'h0);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hazard jal unused rs in_ready: got %b want 1", in_ready); end
    drive(6'h00, 6'h21, 16'h0, 32'h504, 5'd0, 5'd5, 32'h0, 32'h0);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hazard rt pending in_ready: got %b want 0", in_ready); end
    fwd_valid = 2'b11;
    fwd_pend = 2'b10;
    fwd_addr = {5'd5, 5'd5};
    drive(6'h00, 6'h21, 16'h0, 32'h508, 5'd5, 5'd0, 32'h0, 32'h0);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hazard youngest ready in_ready: got %b want 1", in_ready); end
    in_valid = 0;
    fwd_valid = 0;
    fwd_pend = 0;
    tick;
  endtask

  task automatic test_back_to_back;
    exp_t e, held;
    drive(6'h09, 6'h00, 16'h0001, 32'h600, 5'd1, 5'd0, 32'hA, 32'h0);
    sb.push_back({32'hA, 32'h1, 32'h600});
    tick;
    held = 'x;
    n_checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL bp first out_valid: got %b want 1", out_valid); end
    else begin
      held = sb.pop_front();
      n_checks++; if ({out_operand_1, out_operand_2, out_pc} !== held) begin n_fail++; $display("FAIL bp first result: got %h/%h/%h want %h/%h/%h", out_operand_1, out_operand_2, out_pc, held.op1, held.op2, held.pc); end
    end
    out_ready = 0;
    drive(6'h0D, 6'h00, 16'h0002, 32'h604, 5'd2, 5'd0, 32'hB, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp hold[%0d] in_ready: got %b want 0", k, in_ready); end
      tick;
      n_checks++; if ({out_valid, out_operand_1, out_operand_2, out_pc} !== {1'b1, held}) begin n_fail++; $display("FAIL bp hold[%0d] outputs: got %b %h/%h/%h want 1 %h/%h/%h", k, out_valid, out_operand_1, out_operand_2, out_pc, held.op1, held.op2, held.pc); end
    end
    out_ready = 1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp resume in_ready: got %b want 1", in_ready); end
    sb.push_back({32'hB, 32'h2, 32'h604});
    for (int k = 0; k < 2; k++) begin
      tick;
      if (k == 0) begin
        drive(6'h0E, 6'h00, 16'h0003, 32'h608, 5'd3, 5'd0, 32'hC, 32'h0);
        sb.push_back({32'hC, 32'h3, 32'h608});
      end else in_valid = 0;
      n_checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL bp stream[%0d] out_valid: got %b want 1", k, out_valid); end
      else begin
        e = sb.pop_front();
        n_checks++; if ({out_operand_1, out_operand_2, out_pc} !== e) begin n_fail++; $display("FAIL bp stream[%0d] result: got %h/%h/%h want %h/%h/%h", k, out_operand_1, out_operand_2, out_pc, e.op1, e.op2, e.pc); end
      end
    end
    tick;
  endtask

  task automatic test_flush;
    exp_t e;
    drive(6'h09, 6'h00, 16'h0004, 32'h700, 5'd1, 5'd0, 32'hD, 32'h0);
    sb.push_back({32'hD, 32'h4, 32'h700});
    tick;
    out_ready = 0;
    n_checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL flush setup out_valid: got %b want 1", out_valid); end
    else begin
      e = sb.pop_front();
      n_checks++; if ({out_operand_1, out_operand_2, out_pc} !== e) begin n_fail++; $display("FAIL flush setup result: got %h/%h/%h want %h/%h/%h", out_operand_1, out_operand_2, out_pc, e.op1, e.op2, e.pc); end
    end
    out_ready = 1;
    flush = 1;
    drive(6'h09, 6'h00, 16'h0005, 32'h704, 5'd1, 5'd0, 32'hE, 32'h0);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush in_ready: got %b want 0", in_ready); end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush out_valid: got %b want 0", out_valid); end
    flush = 0;
    in_valid = 0;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush dropped instr appeared: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_stall;
    exp_t e;
    drive(6'h09, 6'h00, 16'h0005, 32'h800, 5'd1, 5'd0, 32'hE, 32'h0);
    sb.push_back({32'hE, 32'h5, 32'h800});
    tick;
    n_checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL rst_mid setup out_valid: got %b want 1", out_valid); end
    else begin
      e = sb.pop_front();
      n_checks++; if ({out_operand_1, out_operand_2, out_pc} !== e) begin n_fail++; $display("FAIL rst_mid setup result: got %h/%h/%h want %h/%h/%h", out_operand_1, out_operand_2, out_pc, e.op1, e.op2, e.pc); end
    end
    out_ready = 0;
    fwd_valid = 2'b01;
    fwd_pend = 2'b01;
    fwd_addr = {5'd0, 5'd5};
    drive(6'h23, 6'h00, 16'h0, 32'h804, 5'd5, 5'd0, 32'h0, 32'h0);
    tick;
    tick;
    #2;
    rst_n = 0;
    #1;
    n_checks++; if ({out_valid, out_operand_1, out_operand_2, out_pc} !== 97'h0) begin n_fail++; $display("FAIL rst_mid outputs: got %b %h/%h/%h want all zero", out_valid, out_operand_1, out_operand_2, out_pc); end
    n_checks++; if (stall_count !== 16'h0) begin n_fail++; $display("FAIL rst_mid stall_count: got %h want 0", stall_count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid in_ready: got %b want 0", in_ready); end
    fwd_valid = 0;
    fwd_pend = 0;
    out_ready = 1;
    drive(6'h0F, 6'h00, 16'h00F0, 32'h900, 5'd2, 5'd0, 32'h3, 32'h0);
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid held in reset out_valid: got %b want 0", out_valid); end
    rst_n = 1;
    sb.push_back({32'h3, 32'h00F00000, 32'h900});
    tick;
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL rst_mid first accept out_valid: got %b want 1", out_valid); end
    else begin
      e = sb.pop_front();
      n_checks++; if ({out_operand_1, out_operand_2, out_pc} !== e) begin n_fail++; $display("FAIL rst_mid first accept result: got %h/%h/%h want %h/%h/%h", out_operand_1, out_operand_2, out_pc, e.op1, e.op2, e.pc); end
    end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid replay out_valid: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_addiu;
    test_ops;
    test_jal_wrap;
    test_bypass;
    test_hazard;
    test_back_to_back;
    test_flush;
    test_reset_mid_stall;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
